// File: rtl/sign_conv_pkg.sv
// Shared definitions for the sign/width converter: conversion mode codes.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sign_conv_pkg;

    typedef logic [1:0] mode_t;

    // Unsigned operand, zero-extended.
    localparam mode_t MODE_ZEXT    = 2'd0;
    // Two's complement operand, sign-extended.
    localparam mode_t MODE_SEXT    = 2'd1;
    // MSB is the sign, remaining bits are the magnitude; -0 maps to 0.
    localparam mode_t MODE_SM2TC   = 2'd2;
    // Result is just the operand's MSB in bit 0.
    localparam mode_t MODE_SIGNBIT = 2'd3;

    // Signed-range modes share overflow and saturation rules.
    function automatic logic mode_is_signed(input mode_t mode);
        return (mode == MODE_SEXT) || (mode == MODE_SM2TC);
    endfunction

endpackage

// File: rtl/sign_conv_core.sv
// Combinational convert + resize: operand -> exact signed value -> OUT_W result with overflow flag.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; optional saturation selected by SIGN_CONV_SAT_EN (wrap when undefined).
module sign_conv_core
    import sign_conv_pkg::*;
#(
    parameter int IN_W  = 8,
    parameter int OUT_W = 16
) (
    input  logic [IN_W-1:0]  in_data,
    input  mode_t            in_mode,
    output logic [OUT_W-1:0] out_data,
    output logic             out_ovf
);

    // One extra bit holds every mode's exact value (ZEXT needs a zero sign bit).
    localparam int EXT_W  = IN_W + 1;
    // Wide enough to hold the exact value and to look above both OUT_W boundaries.
    localparam int WIDE_W = ((EXT_W > OUT_W) ? EXT_W : OUT_W) + 1;

    logic signed [EXT_W-1:0]  exact;
    logic signed [EXT_W-1:0]  mag_ext;
    logic signed [WIDE_W-1:0] wide;
    logic signed [WIDE_W-1:0] hi_u;
    logic signed [WIDE_W-1:0] hi_s;
    logic                     fits_u;
    logic                     fits_s;
    logic [OUT_W-1:0]         wrap_data;

    assign mag_ext = {2'b00, in_data[IN_W-2:0]};

    // Build the exact value of the operand under the selected interpretation.
    always_comb begin
        exact = '0;
        case (in_mode)
            MODE_ZEXT:    exact = {1'b0, in_data};
            MODE_SEXT:    exact = {in_data[IN_W-1], in_data};
            MODE_SM2TC:   exact = in_data[IN_W-1] ? -mag_ext : mag_ext;
            MODE_SIGNBIT: exact = {{IN_W{1'b0}}, in_data[IN_W-1]};
            default:      exact = '0;
        endcase
    end

    assign wide = {{(WIDE_W-EXT_W){exact[EXT_W-1]}}, exact};

    // Unsigned fit: nothing set at or above bit OUT_W.
    // Signed fit: bits from OUT_W-1 upward are all copies of the sign.
    assign hi_u   = wide >>> OUT_W;
    assign hi_s   = wide >>> (OUT_W - 1);
    assign fits_u = (hi_u == '0);
    assign fits_s = (hi_s == '0) || (hi_s == '1);

    assign wrap_data = wide[OUT_W-1:0];

    // Overflow flag per mode; a single sign bit always fits.
    always_comb begin
        out_ovf = 1'b0;
        if (in_mode == MODE_ZEXT) begin
            out_ovf = !fits_u;
        end else if (mode_is_signed(in_mode)) begin
            out_ovf = !fits_s;
        end
    end

`ifdef SIGN_CONV_SAT_EN
    // Clamp to the nearest representable extreme on overflow.
    always_comb begin
        out_data = wrap_data;
        if (out_ovf) begin
            if (in_mode == MODE_ZEXT) begin
                out_data = '1;
            end else if (wide[WIDE_W-1]) begin
                out_data = {1'b1, {(OUT_W-1){1'b0}}};
            end else begin
                out_data = {1'b0, {(OUT_W-1){1'b1}}};
            end
        end
    end
`else
    // Keep the low OUT_W bits of the exact value.
    always_comb begin
        out_data = wrap_data;
    end
`endif

endmodule

// File: rtl/sign_conv_pipe.sv
// Two-stage pipelined sign/width converter with overflow flag and saturating overflow-event counter.
// Latency: 2 cycles from accept to out_valid; throughput 1 beat/cycle.
// Backpressure: valid/ready both sides, in_ready combinational from out_ready; stalls hold both stages. SIGN_CONV_SAT_EN selects saturation.
module sign_conv_pipe
    import sign_conv_pkg::*;
#(
    parameter int IN_W  = 8,
    parameter int OUT_W = 16,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_ovf,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] ovf_cnt
);

    // Stage 1: raw operand and mode.
    logic             s1_v;
    logic [IN_W-1:0]  s1_data;
    mode_t            s1_mode;

    // Stage 2: converted result, drives the output port directly.
    logic             s2_v;
    logic [OUT_W-1:0] s2_data;
    logic             s2_ovf;

    logic             s2_free;
    logic             s1_free;
    logic             in_fire;
    logic             out_fire;

    logic [OUT_W-1:0] conv_data;
    logic             conv_ovf;

    // A stage may take new content when empty or when its content leaves this cycle.
    assign s2_free  = !s2_v || out_ready;
    assign s1_free  = !s1_v || s2_free;
    assign in_ready = s1_free;
    assign in_fire  = in_valid && in_ready;
    assign out_fire = s2_v && out_ready;

    sign_conv_core #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_core (
        .in_data  (s1_data),
        .in_mode  (s1_mode),
        .out_data (conv_data),
        .out_ovf  (conv_ovf)
    );

    // Stage 1 capture; contents held while the stage is blocked.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v    <= 1'b0;
            s1_data <= '0;
            s1_mode <= MODE_ZEXT;
        end else if (s1_free) begin
            s1_v <= in_valid;
            if (in_fire) begin
                s1_data <= in_data;
                s1_mode <= in_mode;
            end
        end
    end

    // Stage 2 capture of the converted beat; data holds its last value when empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_v    <= 1'b0;
            s2_data <= '0;
            s2_ovf  <= 1'b0;
        end else if (s2_free) begin
            s2_v <= s1_v;
            if (s1_v) begin
                s2_data <= conv_data;
                s2_ovf  <= conv_ovf;
            end
        end
    end

    // Count delivered overflowed beats, saturating; a clear beats a simultaneous increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_cnt <= '0;
        end else if (cnt_clr) begin
            ovf_cnt <= '0;
        end else if (out_fire && s2_ovf && (ovf_cnt != '1)) begin
            ovf_cnt <= ovf_cnt + 1'b1;
        end
    end

    assign out_valid = s2_v;
    assign out_data  = s2_data;
    assign out_ovf   = s2_ovf;

endmodule

// File: tb/tb_sign_conv_pipe.sv
// Bench for sign_conv_pipe: a 16-bit-output instance and a 4-bit-output / 2-bit-counter instance.
// Expected results are pushed to per-instance queues at accept time and popped at delivery.
// Expectations follow SIGN_CONV_SAT_EN when the bench is built with it.
module tb_sign_conv_pipe;
    import sign_conv_pkg::*;

`ifdef SIGN_CONV_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_ovf, a_cnt_clr;
    logic [7:0]  a_in_data;
    logic [1:0]  a_in_mode;
    logic [15:0] a_out_data, a_ovf_cnt;

    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_ovf, b_cnt_clr;
    logic [7:0]  b_in_data;
    logic [1:0]  b_in_mode;
    logic [3:0]  b_out_data;
    logic [1:0]  b_ovf_cnt;

    sign_conv_pipe #(.IN_W(8), .OUT_W(16), .CNT_W(16)) u_a (
        .clk(clk), .rst_n(rst_n),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data), .in_mode(a_in_mode),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data), .out_ovf(a_out_ovf),
        .cnt_clr(a_cnt_clr), .ovf_cnt(a_ovf_cnt)
    );

    sign_conv_pipe #(.IN_W(8), .OUT_W(4), .CNT_W(2)) u_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_mode(b_in_mode),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data), .out_ovf(b_out_ovf),
        .cnt_clr(b_cnt_clr), .ovf_cnt(b_ovf_cnt)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int a_n_out = 0;

    // {ovf, data zero-padded to 16 bits}
    logic [16:0] a_q[$];
    logic [16:0] b_q[$];

    typedef struct {
        logic [7:0]  d;
        logic [1:0]  m;
        logic [15:0] ed;
        logic        eo;
    } vec_t;

    vec_t t16[8];
    vec_t t4[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: bound expired / unexpected event", name);
    endtask

    // Reference conversion on plain integers.
    function automatic logic [16:0] model(input logic [7:0] d, input logic [1:0] m, input int ow);
        int v, r, maxu, maxs, mins;
        logic ovf;
        maxu = (1 << ow) - 1;
        maxs = (1 << (ow - 1)) - 1;
        mins = -(1 << (ow - 1));
        case (m)
            MODE_ZEXT:  v = {24'b0, d};
            MODE_SEXT:  v = {{24{d[7]}}, d};
            MODE_SM2TC: v = d[7] ? -int'({25'b0, d[6:0]}) : int'({25'b0, d[6:0]});
            default:    v = {31'b0, d[7]};
        endcase
        if (m == MODE_ZEXT)                          ovf = (v > maxu);
        else if (m == MODE_SEXT || m == MODE_SM2TC)  ovf = (v > maxs) || (v < mins);
        else                                         ovf = 1'b0;
        r = v;
        if (SAT && ovf) r = (m == MODE_ZEXT) ? maxu : ((v < 0) ? mins : maxs);
        r = r & maxu;
        return {ovf, r[15:0]};
    endfunction

    task automatic a_send(input logic [7:0] d, input logic [1:0] m, input logic [16:0] exp);
        bit done;
        done = 1'b0;
        a_in_valid = 1'b1;
        a_in_data  = d;
        a_in_mode  = m;
        for (int i = 0; i < 64 && !done; i++) begin
            @(negedge clk);
            if (a_in_ready) begin
                a_q.push_back(exp);
                done = 1'b1;
            end
        end
        if (!done) fail_now("a_accept_timeout");
        @(posedge clk);
        #1;
    endtask

    task automatic b_send(input logic [7:0] d, input logic [1:0] m, input logic [16:0] exp);
        bit done;
        done = 1'b0;
        b_in_valid = 1'b1;
        b_in_data  = d;
        b_in_mode  = m;
        for (int i = 0; i < 64 && !done; i++) begin
            @(negedge clk);
            if (b_in_ready) begin
                b_q.push_back(exp);
                done = 1'b1;
            end
        end
        if (!done) fail_now("b_accept_timeout");
        @(posedge clk);
        #1;
    endtask

    task automatic a_drain();
        for (int i = 0; i < 64 && a_q.size() != 0; i++) @(negedge clk);
        if (a_q.size() != 0) fail_now("a_drain_timeout");
        @(posedge clk);
        #1;
    endtask

    task automatic b_drain();
        for (int i = 0; i < 64 && b_q.size() != 0; i++) @(negedge clk);
        if (b_q.size() != 0) fail_now("b_drain_timeout");
        @(posedge clk);
        #1;
    endtask

    // Delivery monitors: scoreboard pop plus hold-stable check while stalled.
    logic [16:0] a_hold, b_hold;
    logic        a_held = 1'b0, b_held = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            a_held = 1'b0;
        end else begin
            if (a_held) check("a_stall_hold", {a_out_valid, a_out_ovf, a_out_data}, {1'b1, a_hold});
            if (a_out_valid && a_out_ready) begin
                a_n_out++;
                if (a_q.size() == 0) fail_now("a_unexpected_beat");
                else check("a_beat", {a_out_ovf, a_out_data}, a_q.pop_front());
            end
            a_held = a_out_valid && !a_out_ready;
            a_hold = {a_out_ovf, a_out_data};
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            b_held = 1'b0;
        end else begin
            if (b_held) check("b_stall_hold", {b_out_valid, b_out_ovf, 12'b0, b_out_data}, {1'b1, b_hold});
            if (b_out_valid && b_out_ready) begin
                if (b_q.size() == 0) fail_now("b_unexpected_beat");
                else check("b_beat", {b_out_ovf, 12'b0, b_out_data}, b_q.pop_front());
            end
            b_held = b_out_valid && !b_out_ready;
            b_hold = {b_out_ovf, 12'b0, b_out_data};
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int start_out;
        int seen;

        t16[0] = '{8'h80, MODE_SEXT,    16'hFF80, 1'b0};
        t16[1] = '{8'h80, MODE_ZEXT,    16'h0080, 1'b0};
        t16[2] = '{8'h85, MODE_SM2TC,   16'hFFFB, 1'b0};
        t16[3] = '{8'h80, MODE_SM2TC,   16'h0000, 1'b0};
        t16[4] = '{8'hC3, MODE_SIGNBIT, 16'h0001, 1'b0};
        t16[5] = '{8'h7F, MODE_SEXT,    16'h007F, 1'b0};
        t16[6] = '{8'hFF, MODE_ZEXT,    16'h00FF, 1'b0};
        t16[7] = '{8'hFF, MODE_SM2TC,   16'hFF81, 1'b0};

        t4[0] = '{8'h12, MODE_ZEXT,    SAT ? 16'h000F : 16'h0002, 1'b1};
        t4[1] = '{8'h80, MODE_SEXT,    SAT ? 16'h0008 : 16'h0000, 1'b1};
        t4[2] = '{8'hFD, MODE_SEXT,    16'h000D, 1'b0};
        t4[3] = '{8'h07, MODE_SM2TC,   16'h0007, 1'b0};
        t4[4] = '{8'h88, MODE_SM2TC,   16'h0008, 1'b0};
        t4[5] = '{8'h89, MODE_SM2TC,   SAT ? 16'h0008 : 16'h0007, 1'b1};
        t4[6] = '{8'h0F, MODE_ZEXT,    16'h000F, 1'b0};
        t4[7] = '{8'h10, MODE_ZEXT,    SAT ? 16'h000F : 16'h0000, 1'b1};
        t4[8] = '{8'hC3, MODE_SIGNBIT, 16'h0001, 1'b0};

        rst_n = 1'b0;
        a_in_valid = 1'b0; a_in_data = '0; a_in_mode = '0; a_out_ready = 1'b1; a_cnt_clr = 1'b0;
        b_in_valid = 1'b0; b_in_data = '0; b_in_mode = '0; b_out_ready = 1'b1; b_cnt_clr = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_a_out_valid", a_out_valid, 0);
        check("rst_a_out_data",  a_out_data, 0);
        check("rst_a_out_ovf",   a_out_ovf, 0);
        check("rst_a_ovf_cnt",   a_ovf_cnt, 0);
        check("rst_b_out_valid", b_out_valid, 0);
        check("rst_b_ovf_cnt",   b_ovf_cnt, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_a_in_ready", a_in_ready, 1);

        // Latency: valid appears on the second edge after accept, not the first
        a_send(8'h80, MODE_SEXT, 17'h0FF80);
        a_in_valid = 1'b0;
        check("lat_after_1", a_out_valid, 0);
        @(posedge clk);
        #1;
        check("lat_after_2", a_out_valid, 1);
        a_drain();

        // Table vectors, back to back
        for (int i = 0; i < 8; i++) a_send(t16[i].d, t16[i].m, {t16[i].eo, t16[i].ed});
        a_in_valid = 1'b0;
        a_drain();
        for (int i = 0; i < 9; i++) b_send(t4[i].d, t4[i].m, {t4[i].eo, t4[i].ed});
        b_in_valid = 1'b0;
        b_drain();

        // Random traffic with random downstream backpressure
        fork
            begin : rnd_a
                logic [7:0] da;
                logic [1:0] ma;
                for (int i = 0; i < 30; i++) begin
                    da = 8'($urandom);
                    ma = 2'($urandom_range(0, 3));
                    a_send(da, ma, model(da, ma, 16));
                end
                a_in_valid = 1'b0;
            end
            begin : rnd_b
                logic [7:0] db;
                logic [1:0] mb;
                for (int i = 0; i < 30; i++) begin
                    db = 8'($urandom);
                    mb = 2'($urandom_range(0, 3));
                    b_send(db, mb, model(db, mb, 4));
                end
                b_in_valid = 1'b0;
            end
            begin : rnd_rdy
                for (int i = 0; i < 80; i++) begin
                    @(posedge clk);
                    #1;
                    a_out_ready = 1'($urandom_range(0, 1));
                    b_out_ready = 1'($urandom_range(0, 1));
                end
                a_out_ready = 1'b1;
                b_out_ready = 1'b1;
            end
        join
        a_drain();
        b_drain();

        // Six-beat stream with a three-cycle downstream stall in the middle
        start_out = a_n_out;
        fork
            begin : stream
                logic [7:0] ds;
                for (int i = 0; i < 6; i++) begin
                    ds = 8'hF0 + 8'(i * 5);
                    a_send(ds, MODE_SEXT, model(ds, MODE_SEXT, 16));
                end
                a_in_valid = 1'b0;
            end
            begin : stall
                repeat (3) @(posedge clk);
                #1;
                a_out_ready = 1'b0;
                repeat (2) @(posedge clk);
                @(negedge clk);
                check("stall_in_ready",  a_in_ready, 0);
                check("stall_out_valid", a_out_valid, 1);
                @(posedge clk);
                #1;
                a_out_ready = 1'b1;
            end
        join
        a_drain();
        check("stream_count", a_n_out - start_out, 6);

        // Overflow counter: clear, non-overflow beat, saturating increments
        b_cnt_clr = 1'b1;
        @(posedge clk);
        #1;
        b_cnt_clr = 1'b0;
        check("cnt_cleared", b_ovf_cnt, 0);
        b_send(8'hFD, MODE_SEXT, model(8'hFD, MODE_SEXT, 4));
        b_in_valid = 1'b0;
        b_drain();
        check("cnt_no_ovf", b_ovf_cnt, 0);
        for (int k = 1; k <= 4; k++) begin
            b_send(8'h12, MODE_ZEXT, model(8'h12, MODE_ZEXT, 4));
            b_in_valid = 1'b0;
            b_drain();
            check($sformatf("cnt_step%0d", k), b_ovf_cnt, (k < 3) ? k : 3);
        end
        // Clear asserted in the same cycle the fifth overflow beat is delivered
        b_send(8'h12, MODE_ZEXT, model(8'h12, MODE_ZEXT, 4));
        b_in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("clr_beat_pending", b_out_valid, 1);
        b_cnt_clr = 1'b1;
        @(posedge clk);
        #1;
        b_cnt_clr = 1'b0;
        check("clr_wins", b_ovf_cnt, 0);
        check("clr_beat_delivered", b_q.size(), 0);

        // Leave one count in B so the async reset of the counter is visible
        b_send(8'h12, MODE_ZEXT, model(8'h12, MODE_ZEXT, 4));
        b_in_valid = 1'b0;
        b_drain();
        check("cnt_before_rst", b_ovf_cnt, 1);

        // Async reset with two beats in flight
        a_out_ready = 1'b0;
        a_send(8'h01, MODE_ZEXT, 17'h00001);
        a_send(8'h02, MODE_ZEXT, 17'h00002);
        a_in_valid = 1'b0;
        check("inflight_valid", a_out_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", a_out_valid, 0);
        check("arst_out_data",  a_out_data, 0);
        check("arst_out_ovf",   a_out_ovf, 0);
        check("arst_b_ovf_cnt", b_ovf_cnt, 0);
        a_q.delete();
        b_q.delete();
        a_out_ready = 1'b1;
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (a_out_valid) seen++;
        end
        check("post_rst_no_beat", seen, 0);
        check("post_rst_in_ready", a_in_ready, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
